// File: rtl/dds_pkg.sv
// Shared types and defaults for the two-channel DDS ROM scheduler.
// Holds the sequencer state encoding and the channel mix rule.
`timescale 1ns/1ps
package dds_pkg;

  localparam int DDS_PHASE_W = 32;
  localparam int DDS_ADDR_W  = 11;
  localparam logic [7:0] MIDSCALE = 8'd128;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    WAIT0,
    RD1,
    WAIT1,
    MIX
  } dds_state_t;

  function automatic logic [7:0] dds_mix(
    input logic [1:0] en,
    input logic [7:0] s0,
    input logic [7:0] s1
  );
    logic [8:0] sum;
    logic [7:0] r;
    sum = {1'b0, s0} + {1'b0, s1};
    r = MIDSCALE;
    unique case (1'b1)
      (en == 2'b11): r = sum[8:1];
      (en == 2'b01): r = s0;
      (en == 2'b10): r = s1;
      default:       r = MIDSCALE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dds_rom_scheduler_if.sv
// Sine BROM read port shared between the scheduler and the ROM.
// The scheduler is the master; the ROM answers on Rom_data.
`timescale 1ns/1ps
interface dds_rom_scheduler_if
  import dds_pkg::*;
#(
  parameter int ADDR_W = DDS_ADDR_W
);

  logic              Rom_en;
  logic [ADDR_W-1:0] Rom_addr;
  logic [7:0]        Rom_data;

  modport master (
    output Rom_en,
    output Rom_addr,
    input  Rom_data
  );

  modport slave (
    input  Rom_en,
    input  Rom_addr,
    output Rom_data
  );

endinterface

// File: rtl/dds_phase_acc.sv
// One DDS channel: pending tuning word plus phase accumulator.
// A load never disturbs the step that happens on the same edge.
`timescale 1ns/1ps
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int PHASE_W = DDS_PHASE_W
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               step,
  input  logic               clear,
  output logic [PHASE_W-1:0] acc
);

  logic [PHASE_W-1:0] pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      acc     <= '0;
    end else begin
      if (load)
        pending <= ftw_in;
      if (clear)
        acc <= '0;
      else if (step)
        acc <= acc + pending;
    end
  end

endmodule

// File: rtl/dds_rom_scheduler.sv
// Two-channel DDS: time-shares one sine BROM between two phase
// accumulators and emits one mixed offset-binary sample per period.
`timescale 1ns/1ps
module dds_rom_scheduler
  import dds_pkg::*;
#(
  parameter int SAMPLE_DIV = 16,
  parameter int PHASE_W    = DDS_PHASE_W,
  parameter int ADDR_W     = DDS_ADDR_W,
  parameter int ROM_LAT    = 1
)(
  input  logic                Clk_100M,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [1:0]          Ch_en,
  input  logic [PHASE_W-1:0]  Ftw0,
  input  logic [PHASE_W-1:0]  Ftw1,
  input  logic                Ftw_load,
  dds_rom_scheduler_if.master rom,
  output logic [7:0]          Sample,
  output logic                Sample_valid,
  output logic                Busy
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(ROM_LAT - 1);

  dds_state_t         state;
  logic [LW-1:0]      lat_cnt;
  logic [DW-1:0]      div_cnt;
  logic               en_q;
  logic               tick;
  logic [7:0]         s0;
  logic [7:0]         s1;
  logic [PHASE_W-1:0] acc0;
  logic [PHASE_W-1:0] acc1;
  logic [ADDR_W-1:0]  addr0;
  logic [ADDR_W-1:0]  addr1;
  logic               at_mix;
  logic               unused_acc;

  assign addr0  = acc0[PHASE_W-1 -: ADDR_W];
  assign addr1  = acc1[PHASE_W-1 -: ADDR_W];
  assign at_mix = (state == MIX);
  assign tick   = Enable && (div_cnt == DIV_LAST);
  assign unused_acc = ^{acc0[PHASE_W-ADDR_W-1:0],
                        acc1[PHASE_W-ADDR_W-1:0]};

  dds_phase_acc #(.PHASE_W(PHASE_W)) u_acc0 (
    .clk    (Clk_100M),
    .reset  (Reset),
    .load   (Ftw_load),
    .ftw_in (Ftw0),
    .step   (at_mix && Ch_en[0]),
    .clear  (at_mix && !Ch_en[0]),
    .acc    (acc0)
  );

  dds_phase_acc #(.PHASE_W(PHASE_W)) u_acc1 (
    .clk    (Clk_100M),
    .reset  (Reset),
    .load   (Ftw_load),
    .ftw_in (Ftw1),
    .step   (at_mix && Ch_en[1]),
    .clear  (at_mix && !Ch_en[1]),
    .acc    (acc1)
  );

  // Counting starts the clock after Enable is first seen, so the
  // first tick lands SAMPLE_DIV clocks after Enable rises.
  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      en_q    <= 1'b0;
      div_cnt <= '0;
    end else begin
      en_q <= Enable;
      if (!Enable || !en_q || tick)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      s0           <= '0;
      s1           <= '0;
      rom.Rom_en   <= 1'b0;
      rom.Rom_addr <= '0;
      Sample       <= MIDSCALE;
      Sample_valid <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      rom.Rom_en   <= 1'b0;
      Sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick) begin
            state        <= RD0;
            rom.Rom_en   <= 1'b1;
            rom.Rom_addr <= addr0;
            Busy         <= 1'b1;
          end
        end
        RD0: begin
          state   <= WAIT0;
          lat_cnt <= '0;
        end
        WAIT0: begin
          if (lat_cnt == LAT_LAST) begin
            s0           <= rom.Rom_data;
            state        <= RD1;
            rom.Rom_en   <= 1'b1;
            rom.Rom_addr <= addr1;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        RD1: begin
          state   <= WAIT1;
          lat_cnt <= '0;
        end
        WAIT1: begin
          if (lat_cnt == LAT_LAST) begin
            s1    <= rom.Rom_data;
            state <= MIX;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        MIX: begin
          Sample       <= dds_mix(Ch_en, s0, s1);
          Sample_valid <= 1'b1;
          state        <= IDLE;
          Busy         <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_rom_scheduler.sv
// Directed bench for dds_rom_scheduler with a one-cycle
// behavioural sine BROM model.
`timescale 1ns/1ps
module tb_dds_rom_scheduler;

  logic        Clk_100M = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic [1:0]  Ch_en = 2'b00;
  logic [31:0] Ftw0 = '0;
  logic [31:0] Ftw1 = '0;
  logic        Ftw_load = 1'b0;
  logic [7:0]  Sample;
  logic        Sample_valid;
  logic        Busy;

  int n_tests = 0;
  int n_fail  = 0;

  int         rom_mode = 0;
  logic [7:0] rom_a = 8'd0;
  logic [7:0] rom_b = 8'd0;
  bit         rd_sel = 1'b0;

  always #5 Clk_100M = ~Clk_100M;

  dds_rom_scheduler_if #(.ADDR_W(11)) rom_bus ();

  dds_rom_scheduler #(
    .SAMPLE_DIV (16),
    .PHASE_W    (32),
    .ADDR_W     (11),
    .ROM_LAT    (1)
  ) dut (
    .Clk_100M     (Clk_100M),
    .Reset        (Reset),
    .Enable       (Enable),
    .Ch_en        (Ch_en),
    .Ftw0         (Ftw0),
    .Ftw1         (Ftw1),
    .Ftw_load     (Ftw_load),
    .rom          (rom_bus),
    .Sample       (Sample),
    .Sample_valid (Sample_valid),
    .Busy         (Busy)
  );

  // mode 0: data = addr[7:0]; mode 1: first read rom_a, second rom_b
  always @(posedge Clk_100M) begin
    if (Reset)
      rd_sel <= 1'b0;
    else if (Sample_valid)
      rd_sel <= 1'b0;
    else if (rom_bus.Rom_en) begin
      if (rom_mode == 0)
        rom_bus.Rom_data <= rom_bus.Rom_addr[7:0];
      else
        rom_bus.Rom_data <= rd_sel ? rom_b : rom_a;
      rd_sel <= ~rd_sel;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    Reset = 1'b1;
    Enable = 1'b0;
    Ch_en = 2'b00;
    Ftw0 = '0;
    Ftw1 = '0;
    Ftw_load = 1'b0;
    rom_mode = 0;
    repeat (3) @(posedge Clk_100M);
    @(negedge Clk_100M);
    Reset = 1'b0;
  endtask

  task automatic load_ftw(input logic [31:0] f0,
                          input logic [31:0] f1);
    @(negedge Clk_100M);
    Ftw0 = f0;
    Ftw1 = f1;
    Ftw_load = 1'b1;
    @(negedge Clk_100M);
    Ftw_load = 1'b0;
  endtask

  // Follows one sample period from its RD0 cycle to the valid cycle.
  task automatic run_period(input bit do_load,
                            input logic [31:0] f0,
                            output logic [10:0] a0,
                            output logic [10:0] a1,
                            output logic [7:0] s,
                            output logic v,
                            output bit ok);
    ok = 1'b0;
    a0 = '0;
    a1 = '0;
    s = '0;
    v = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge Clk_100M);
      #1;
      if (rom_bus.Rom_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    a0 = rom_bus.Rom_addr;
    repeat (2) begin
      @(posedge Clk_100M);
      #1;
    end
    a1 = rom_bus.Rom_addr;
    repeat (2) begin
      @(posedge Clk_100M);
      #1;
    end
    if (do_load) begin
      Ftw0 = f0;
      Ftw_load = 1'b1;
    end
    @(posedge Clk_100M);
    #1;
    Ftw_load = 1'b0;
    v = Sample_valid;
    s = Sample;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++;
    if (Sample !== 8'd128) begin
      n_fail++;
      $display("FAIL reset_sample: got %0d expected 128", Sample);
    end
    n_tests++;
    if (Sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", Sample_valid);
    end
    n_tests++;
    if (rom_bus.Rom_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rom_en: got %b expected 0", rom_bus.Rom_en);
    end
    n_tests++;
    if (rom_bus.Rom_addr !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d expected 0",
               rom_bus.Rom_addr);
    end
    n_tests++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", Busy);
    end
  endtask

  task automatic test_idle_period();
    int n;
    int m;
    int ren;
    apply_reset();
    Ch_en = 2'b00;
    @(negedge Clk_100M);
    Enable = 1'b1;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge Clk_100M);
      #1;
      if (Sample_valid) begin
        n = i;
        break;
      end
    end
    n_tests++;
    if (n != 22) begin
      n_fail++;
      $display("FAIL first_valid_latency: got %0d expected 22", n);
    end
    n_tests++;
    if (Sample !== 8'd128) begin
      n_fail++;
      $display("FAIL idle_sample: got %0d expected 128", Sample);
    end
    m = -1;
    ren = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk_100M);
      #1;
      if (rom_bus.Rom_en) ren++;
      if (Sample_valid) begin
        m = i;
        break;
      end
    end
    n_tests++;
    if (m != 16) begin
      n_fail++;
      $display("FAIL valid_period: got %0d expected 16", m);
    end
    n_tests++;
    if (ren != 2) begin
      n_fail++;
      $display("FAIL rom_reads_per_period: got %0d expected 2", ren);
    end
    n_tests++;
    if (Sample !== 8'd128) begin
      n_fail++;
      $display("FAIL idle_sample2: got %0d expected 128", Sample);
    end
  endtask

  task automatic test_sweep();
    logic [10:0] a0, a1, ea;
    logic [7:0]  s, es;
    logic        v;
    bit          ok;
    apply_reset();
    Ch_en = 2'b01;
    rom_mode = 0;
    load_ftw(32'h0020_0000, 32'd0);
    @(negedge Clk_100M);
    Enable = 1'b1;
    for (int k = 0; k <= 2048; k++) begin
      run_period(1'b0, 32'd0, a0, a1, s, v, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL sweep_timeout[%0d]: got none expected RD0", k);
        break;
      end
      ea = 11'(k);
      es = 8'(k);
      n_tests++;
      if (a0 !== ea) begin
        n_fail++;
        $display("FAIL sweep_addr[%0d]: got %0d expected %0d",
                 k, a0, ea);
      end
      n_tests++;
      if (s !== es || v !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_sample[%0d]: got %0d/%b expected %0d/1",
                 k, s, v, es);
      end
    end
    Enable = 1'b0;
  endtask

  task automatic test_mix();
    logic [10:0] a0, a1;
    logic [7:0]  s;
    logic        v;
    bit          ok;
    logic [1:0]  en_t [5]  = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    logic [7:0]  a_t  [5]  = '{8'd200, 8'd255, 8'd200, 8'd200, 8'd200};
    logic [7:0]  b_t  [5]  = '{8'd101, 8'd255, 8'd101, 8'd101, 8'd101};
    logic [7:0]  exp_t [5] = '{8'd150, 8'd255, 8'd101, 8'd200, 8'd128};
    apply_reset();
    rom_mode = 1;
    @(negedge Clk_100M);
    Enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Ch_en = en_t[i];
      rom_a = a_t[i];
      rom_b = b_t[i];
      run_period(1'b0, 32'd0, a0, a1, s, v, ok);
      n_tests++;
      if (!ok || v !== 1'b1 || s !== exp_t[i]) begin
        n_fail++;
        $display("FAIL mix[%0d]: got %0d (ok=%b v=%b) expected %0d",
                 i, s, ok, v, exp_t[i]);
      end
    end
    Enable = 1'b0;
  endtask

  task automatic test_ftw_load_at_mix();
    logic [10:0] a0, a1;
    logic [7:0]  s;
    logic        v;
    bit          ok;
    logic [10:0] exp_a [6] = '{11'd0, 11'd1024, 11'd0,
                               11'd1024, 11'd1025, 11'd1026};
    apply_reset();
    Ch_en = 2'b01;
    rom_mode = 0;
    load_ftw(32'h8000_0000, 32'd0);
    @(negedge Clk_100M);
    Enable = 1'b1;
    for (int p = 0; p < 6; p++) begin
      run_period(p == 2, 32'h0020_0000, a0, a1, s, v, ok);
      n_tests++;
      if (!ok || a0 !== exp_a[p]) begin
        n_fail++;
        $display("FAIL ftw_load_addr[%0d]: got %0d (ok=%b) expected %0d",
                 p, a0, ok, exp_a[p]);
      end
    end
    Enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit found;
    int nv;
    int ren;
    apply_reset();
    Ch_en = 2'b00;
    @(negedge Clk_100M);
    Enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge Clk_100M);
      #1;
      if (rom_bus.Rom_en) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_rd0_busy: got found=%b busy=%b expected 1/1",
               found, Busy);
    end
    repeat (2) begin
      @(posedge Clk_100M);
      #1;
    end
    n_tests++;
    if (rom_bus.Rom_en !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_at_rd1: got %b expected 1", rom_bus.Rom_en);
    end
    Enable = 1'b0;
    nv = 0;
    ren = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk_100M);
      #1;
      if (Sample_valid) nv++;
      if (rom_bus.Rom_en) ren++;
    end
    n_tests++;
    if (nv != 1) begin
      n_fail++;
      $display("FAIL drop_valid_count: got %0d expected 1", nv);
    end
    n_tests++;
    if (ren != 0) begin
      n_fail++;
      $display("FAIL drop_rom_reads: got %0d expected 0", ren);
    end
    n_tests++;
    if (Busy !== 1'b0 || Sample !== 8'd128) begin
      n_fail++;
      $display("FAIL drop_park: got busy=%b sample=%0d expected 0/128",
               Busy, Sample);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] a0, a1;
    logic [7:0]  s;
    logic        v;
    bit          ok;
    bit          found;
    int          nv;
    apply_reset();
    Ch_en = 2'b01;
    rom_mode = 0;
    load_ftw(32'h0020_0000, 32'd0);
    @(negedge Clk_100M);
    Enable = 1'b1;
    run_period(1'b0, 32'd0, a0, a1, s, v, ok);
    n_tests++;
    if (!ok || s !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %0d (ok=%b) expected 0", s, ok);
    end
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge Clk_100M);
      #1;
      if (rom_bus.Rom_en) begin
        found = 1'b1;
        break;
      end
    end
    @(posedge Clk_100M);
    #1;
    Reset = 1'b1;
    #1;
    n_tests++;
    if (!found || rom_bus.Rom_en !== 1'b0 ||
        rom_bus.Rom_addr !== 11'd0) begin
      n_fail++;
      $display("FAIL rstmid_rom: got en=%b addr=%0d expected 0/0",
               rom_bus.Rom_en, rom_bus.Rom_addr);
    end
    n_tests++;
    if (Sample !== 8'd128 || Busy !== 1'b0 ||
        Sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_out: got s=%0d busy=%b v=%b expected 128/0/0",
               Sample, Busy, Sample_valid);
    end
    nv = 0;
    repeat (8) begin
      @(posedge Clk_100M);
      #1;
      if (Sample_valid) nv++;
    end
    n_tests++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL rstmid_novalid: got %0d expected 0", nv);
    end
    @(negedge Clk_100M);
    Reset = 1'b0;
    Enable = 1'b0;
  endtask

  task automatic test_clear_ch0();
    logic [10:0] a0, a1;
    logic [7:0]  s;
    logic        v;
    bit          ok;
    logic [1:0]  en_t  [6] = '{2'b01, 2'b01, 2'b00,
                               2'b00, 2'b01, 2'b01};
    logic [10:0] exp_a [6] = '{11'd0, 11'd1, 11'd2,
                               11'd0, 11'd0, 11'd1};
    logic [7:0]  exp_s [6] = '{8'd0, 8'd1, 8'd128,
                               8'd128, 8'd0, 8'd1};
    apply_reset();
    rom_mode = 0;
    load_ftw(32'h0020_0000, 32'd0);
    @(negedge Clk_100M);
    Enable = 1'b1;
    for (int p = 0; p < 6; p++) begin
      Ch_en = en_t[p];
      run_period(1'b0, 32'd0, a0, a1, s, v, ok);
      n_tests++;
      if (!ok || a0 !== exp_a[p] || s !== exp_s[p]) begin
        n_fail++;
        $display("FAIL clear_ch0[%0d]: got a=%0d s=%0d expected %0d/%0d",
                 p, a0, s, exp_a[p], exp_s[p]);
      end
    end
    Enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_period();
    test_mix();
    test_ftw_load_at_mix();
    test_enable_drop();
    test_reset_mid();
    test_clear_ch0();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
